// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a first-word-fall-through FIFO. It pops one word per frame and sends
// start, DBIT data bits LSB-first, an optional parity bit and a stop period, paced by a 16x baud tick.
module uart_tx_fifo #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PAR_EN  = 0,
    parameter int PAR_ODD = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_r_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int SW = $clog2(SB_TICK);
    localparam int NW = $clog2(DBIT);
    localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
    localparam logic          P_INIT      = (PAR_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            p_q, p_d;
    logic            tx_q, tx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            p_q     <= p_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    b_d     = fifo_r_data;
                    p_d     = P_INIT;
                    s_d     = '0;
                    n_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        p_d = p_q ^ b_q[0];
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = (PAR_EN != 0) ? PARITY : STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        s_d     = '0;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is chosen from the next state so tx changes on the same edge as the state.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            PARITY:  tx_d = p_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        // Gated with rst_n so no pop escapes while reset is held with a non-empty FIFO.
        fifo_rd      = rst_n && (state_q == IDLE) && !fifo_empty;
        tx_busy      = (state_q != IDLE);
        tx_done_tick = (state_q == STOP) && s_tick && (s_q == S_STOP_LAST);
        tx           = tx_q;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmitter that drains the transmit-side FIFO buffer and serialises each byte onto the `tx` line. It sits between the transmit FIFO (on its read port) and the baud-rate generator (on its oversampling tick). Each frame is one start bit, DBIT data bits LSB-first, an optional parity bit, and a stop period. The block pops exactly one FIFO word per frame.

## Interface
Parameters:
- DBIT, 8: data bits per frame, 5..8.
- SB_TICK, 16: oversampling ticks in the stop period. 16 gives 1 stop bit, 24 gives 1.5, 32 gives 2.
- PAR_EN, 0: 1 inserts a parity bit after the data bits.
- PAR_ODD, 0: parity sense when PAR_EN=1. 0 is even, 1 is odd.

Ports:
- clk  in  1  system clock; sole clock of the block.
- rst_n  in  1  reset. Asynchronous and active-low: assertion takes effect immediately; release is sampled on the clk rising edge.
- s_tick  in  1  one-clk-wide strobe at 16x the baud rate.
- fifo_empty  in  1  FIFO empty flag.
- fifo_r_data  in  DBIT  FIFO head word. Valid combinationally whenever fifo_empty=0 (first-word-fall-through).
- fifo_rd  out  1  one-cycle pop strobe to the FIFO read input.
- tx  out  1  serial output; idle/mark level is 1.
- tx_busy  out  1  1 in every state except IDLE.
- tx_done_tick  out  1  one-cycle pulse at the end of each frame's stop period.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. A tick counter `s` counts 0..SB_TICK-1 (width $clog2(SB_TICK)). A bit counter `n` counts 0..DBIT-1. A DBIT-wide shift register `b` holds the frame. A parity accumulator `p` is 1 bit.
- **IDLE:** tx=1.
  - If fifo_empty=0: load b<=fifo_r_data, p<=PAR_ODD, s<=0, n<=0. Pulse fifo_rd for this cycle. Go to START.
  - If fifo_empty=1: stay in IDLE.
- **START:** tx=0.
  - On s_tick with s=15: s<=0, go to DATA.
  - On s_tick otherwise: s<=s+1.
- **DATA:** tx=b[0].
  - On s_tick with s=15: s<=0, p<=p^b[0], b<=b>>1.
  - Then if n=DBIT-1, go to PARITY when PAR_EN=1, else go to STOP.
  - Otherwise n<=n+1 and stay in DATA.
- **PARITY:** tx=p. On s_tick with s=15: s<=0, go to STOP.
- **STOP:** tx=1. On s_tick with s=SB_TICK-1: pulse tx_done_tick, go to IDLE.
- **Reset values:** state=IDLE, tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0, s=0, n=0, b=0, p=0.
- tx is registered: it is driven from a tx_reg updated alongside the state, never decoded combinationally.
- s_tick is ignored in IDLE.
- The block never asserts fifo_rd while fifo_empty=1.
- fifo_r_data is sampled only in the fifo_rd cycle. Later changes to the FIFO head do not affect the frame in flight.

## Timing
- Pop latency: fifo_rd asserts in the first clk edge window in which state=IDLE and fifo_empty=0. The following cycle is in START.
- tx falls to 0 one clk after the fifo_rd cycle.
- Bit durations:
  - Start bit: 16 s_tick.
  - Each data bit: 16 s_tick.
  - Parity bit: 16 s_tick.
  - Stop period: SB_TICK s_tick.
- A frame with PAR_EN=0 and the defaults spans 16*(1+DBIT)+SB_TICK ticks, i.e. 160 ticks.
- Back-to-back frames:
  - tx_done_tick and the return to IDLE occur on the same edge.
  - The next fifo_rd follows one clk later if the FIFO is non-empty.
  - tx stays 1 across that gap.
- Reset mid-frame: tx returns to 1 and all outputs return to reset values immediately. The in-flight word is discarded (it was already popped). No tx_done_tick is issued.
- A FIFO write arriving while a frame is in flight has no effect until the block returns to IDLE.

## Test plan
- **Single byte:** s_tick every 4 clk, defaults. Push 0xA5.
  - One fifo_rd pulse.
  - tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each level held 64 clk.
  - tx_done_tick fires exactly once, 640 clk after start-bit entry.
- **Back-to-back:** push 0x00, 0xFF, 0x3C.
  - Three fifo_rd pulses, each exactly one clk after the previous tx_done_tick.
  - Frames are decoded correctly by a bench receiver model.
  - fifo_empty=1 after the third pop.
- **Empty FIFO:** hold fifo_empty=1 for 1000 clk with s_tick running.
  - fifo_rd=0, tx=1, tx_busy=0 throughout.
- **Parity:** PAR_EN=1 with 0x07.
  - PAR_ODD=0: parity bit=1.
  - PAR_ODD=1: parity bit=0.
  - Stop bit follows 16 ticks later.
- **Stop length:** SB_TICK=32. Measured stop period is 32 s_tick, with tx=1 throughout.
- **Reset mid-frame:** assert rst_n=0 during data bit 3 of 0x55.
  - tx=1 and tx_busy=0 without waiting for a clk edge.
  - After release, the next queued word transmits intact and there is no stray tx_done_tick.
